// File: rtl/exp_sum_normalizer.sv
// Softmax denominator front end: accumulates exp() terms into a saturating
// 16-bit sum, then left-aligns it (mantissa + shift) for the reciprocal stage.

module priority_encoder_16bit (
    input  logic [15:0] vec,
    output logic [3:0]  pos,
    output logic        zero
);
    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        pos  = 4'd0;
        zero = (vec == 16'd0);
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) pos = 4'(i);
        end
    end
endmodule

module exp_sum_normalizer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_mant,
    output logic [3:0]       out_shift,
    output logic [3:0]       out_pos,
    output logic             out_zero,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_count
);
    typedef enum logic [1:0] {ACCUM, NORM, OUT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Bit 16 of the result flags that the true sum overflowed 16 bits.
    function automatic logic [16:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? {1'b1, 16'hFFFF} : s;
    endfunction

    function automatic logic [3:0] norm_shift(input logic [3:0] pos, input logic zero);
        return zero ? 4'd0 : (4'd15 - pos);
    endfunction

    function automatic logic [15:0] norm_mant(input logic [15:0] sum, input logic [3:0] shift,
                                              input logic zero);
        return zero ? 16'd0 : (sum << shift);
    endfunction

    state_t            state_q;
    logic [15:0]       sum_q;
    logic              sat_q;
    logic [CNT_W-1:0]  count_q;
    logic              out_valid_q;
    logic [15:0]       out_mant_q;
    logic [3:0]        out_shift_q;
    logic [3:0]        out_pos_q;
    logic              out_zero_q;
    logic              out_sat_q;
    logic [CNT_W-1:0]  out_count_q;

    logic [16:0]       sum_d;
    logic [CNT_W-1:0]  count_d;
    logic [3:0]        enc_pos;
    logic              enc_zero;
    logic [3:0]        shift_d;
    logic [15:0]       mant_d;
    logic              accept;

    priority_encoder_16bit u_penc (
        .vec  (sum_q),
        .pos  (enc_pos),
        .zero (enc_zero)
    );

    assign in_ready = (state_q == ACCUM);
    assign accept   = in_valid && in_ready;
    assign sum_d    = sat_add(sum_q, in_data);
    assign count_d  = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
    assign shift_d  = norm_shift(enc_pos, enc_zero);
    assign mant_d   = norm_mant(sum_q, shift_d, enc_zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            sum_q       <= 16'd0;
            sat_q       <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_mant_q  <= 16'd0;
            out_shift_q <= 4'd0;
            out_pos_q   <= 4'd0;
            out_zero_q  <= 1'b1;
            out_sat_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        sum_q   <= sum_d[15:0];
                        sat_q   <= sat_q | sum_d[16];
                        count_q <= count_d;
                        if (in_last) state_q <= NORM;
                    end
                end
                // Encoder output is captured here so the output fields come from flops.
                NORM: begin
                    out_pos_q   <= enc_pos;
                    out_zero_q  <= enc_zero;
                    out_shift_q <= shift_d;
                    out_mant_q  <= mant_d;
                    out_sat_q   <= sat_q;
                    out_count_q <= count_q;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        sum_q       <= 16'd0;
                        sat_q       <= 1'b0;
                        count_q     <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_mant  = out_mant_q;
    assign out_shift = out_shift_q;
    assign out_pos   = out_pos_q;
    assign out_zero  = out_zero_q;
    assign out_sat   = out_sat_q;
    assign out_count = out_count_q;
endmodule

// File: tb/tb_exp_sum_normalizer.sv
// Directed bench for exp_sum_normalizer, built with a 2-bit element counter
// so count saturation is reachable with short vectors.

module tb_exp_sum_normalizer;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [15:0]      in_data = 16'd0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [15:0]      out_mant;
    logic [3:0]       out_shift;
    logic [3:0]       out_pos;
    logic             out_zero;
    logic             out_sat;
    logic [CNT_W-1:0] out_count;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] vec_mem [8];
    int          vec_len;

    exp_sum_normalizer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_shift (out_shift),
        .out_pos   (out_pos),
        .out_zero  (out_zero),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the beat until the DUT takes it; in_ready depends only on state.
    task automatic beat(input logic [15:0] d, input logic l);
        logic acc;
        int   guard;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        guard    = 0;
        acc      = 1'b0;
        while (!acc && guard < 20) begin
            acc = in_ready;
            tick();
            guard++;
        end
        if (!acc) check("beat_accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        int guard;
        guard = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        check("out_valid_wait", 32'(out_valid), 32'd1);
    endtask

    task automatic check_out(input string tag, input logic [3:0] pos, input logic [3:0] shift,
                             input logic [15:0] mant, input logic zero, input logic sat,
                             input logic [CNT_W-1:0] cnt);
        check({tag, "_pos"},   32'(out_pos),   32'(pos));
        check({tag, "_shift"}, 32'(out_shift), 32'(shift));
        check({tag, "_mant"},  32'(out_mant),  32'(mant));
        check({tag, "_zero"},  32'(out_zero),  32'(zero));
        check({tag, "_sat"},   32'(out_sat),   32'(sat));
        check({tag, "_count"}, 32'(out_count), 32'(cnt));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_out(tag, 4'd0, 4'd0, 16'd0, 1'b1, 1'b0, '0);
    endtask

    // Reference: saturating 17-bit accumulation and a leading-one search.
    task automatic run_vec(input string tag);
        int          s;
        logic        sat;
        int          cnt;
        logic [15:0] s16;
        logic [3:0]  p;
        logic [3:0]  sh;
        s   = 0;
        sat = 1'b0;
        cnt = 0;
        for (int i = 0; i < vec_len; i++) begin
            s = s + int'(vec_mem[i]);
            if (s > 65535) begin
                s   = 65535;
                sat = 1'b1;
            end
            if (cnt < 3) cnt++;
            repeat ($urandom_range(0, 2)) tick();
            beat(vec_mem[i], (i == vec_len - 1));
        end
        s16 = 16'(s);
        p   = 4'd0;
        for (int b = 0; b < 16; b++) if (s16[b]) p = 4'(b);
        sh  = (s16 == 16'd0) ? 4'd0 : 4'd15 - p;
        wait_valid();
        check_out(tag, p, sh, (s16 == 16'd0) ? 16'd0 : 16'(s16 << sh), (s16 == 16'd0), sat,
                  CNT_W'(cnt));
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        // 0x0003 + 0x0005 = 0x0008
        out_ready = 1'b1;
        beat(16'h0003, 1'b0);
        beat(16'h0005, 1'b1);
        check("v1_valid_k",   32'(out_valid), 32'd0);
        check("v1_ready_k",   32'(in_ready),  32'd0);
        tick();
        check("v1_valid_k1",  32'(out_valid), 32'd1);
        check_out("v1", 4'd3, 4'd12, 16'h8000, 1'b0, 1'b0, 2'd2);
        tick();
        check("v1_valid_hs",  32'(out_valid), 32'd0);
        check("v1_ready_hs",  32'(in_ready),  32'd1);

        // 0xF000 + 0x2000 saturates
        beat(16'hF000, 1'b0);
        beat(16'h2000, 1'b1);
        wait_valid();
        check_out("v2", 4'd15, 4'd0, 16'hFFFF, 1'b0, 1'b1, 2'd2);
        tick();

        // Single zero element
        beat(16'h0000, 1'b1);
        wait_valid();
        check_out("v3", 4'd0, 4'd0, 16'h0000, 1'b1, 1'b0, 2'd1);
        tick();

        // Back-pressure: outputs hold, pending beat is not taken
        out_ready = 1'b0;
        beat(16'h0123, 1'b1);
        wait_valid();
        in_valid = 1'b1;
        in_data  = 16'h0001;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("v4_hold_valid", 32'(out_valid), 32'd1);
            check("v4_hold_ready", 32'(in_ready),  32'd0);
            check("v4_hold_mant",  32'(out_mant),  32'h9180);
            check("v4_hold_pos",   32'(out_pos),   32'd8);
            check("v4_hold_shift", 32'(out_shift), 32'd7);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("v4_hs_valid", 32'(out_valid), 32'd0);
        check("v4_hs_ready", 32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("v4b_ready_after_accept", 32'(in_ready), 32'd0);
        wait_valid();
        check_out("v4b", 4'd0, 4'd15, 16'h8000, 1'b0, 1'b0, 2'd1);
        tick();

        // Asynchronous reset mid-vector
        beat(16'h0010, 1'b0);
        beat(16'h0010, 1'b0);
        beat(16'h0010, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        tick();
        rst_n = 1'b1;
        tick();
        beat(16'h0100, 1'b1);
        wait_valid();
        check_out("v5", 4'd8, 4'd7, 16'h8000, 1'b0, 1'b0, 2'd1);
        tick();

        // Asynchronous reset while a result is waiting
        out_ready = 1'b0;
        beat(16'h0040, 1'b1);
        wait_valid();
        #2 rst_n = 1'b0;
        #1;
        check_reset("rst_out");
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back vectors with random gaps; count saturates at 3
        out_ready = 1'b1;
        vec_mem[0] = 16'h1000; vec_mem[1] = 16'h2000; vec_mem[2] = 16'h0300;
        vec_mem[3] = 16'h0040; vec_mem[4] = 16'h0005;
        vec_len = 5;
        run_vec("v6a");
        check("v6a_count_sat", 32'(out_count), 32'd3);
        check("v6a_mant_hand", 32'(out_mant),  32'hCD14);
        vec_mem[0] = 16'h8000; vec_mem[1] = 16'h9000;
        vec_len = 2;
        run_vec("v6b");
        vec_mem[0] = 16'h0007; vec_mem[1] = 16'h0001; vec_mem[2] = 16'h0010;
        vec_len = 3;
        run_vec("v6c");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
